pipelined_control_unit: RTL and testbench

//  Next-gen main control for the 5-stage RV32I pipeline. Decodes the full base opcode set in ID
//  (R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC) and carries the control bundle through
//  ID/EX, EX/MEM and MEM/WB registers. Also provides load-use stall, taken-branch flush and
//  EX-operand forwarding selects. Sits between IF/ID and the datapath stage registers.

---
 rtl/pipelined_control_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit
//
// Main control for a 5-stage RV32I pipeline. Decodes the base opcode set in
// ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB stage
// registers. It also generates:
//   - the load-use stall (or a full RAW stall when forwarding is disabled),
//   - the IF/ID flush on a taken branch or jump,
//   - the EX operand forwarding selects.
//
// Ports
//   clk, reset               clock (rising edge), synchronous active-high reset
//   id_valid                 IF/ID holds a valid instruction
//   id_opcode                instr[6:0]
//   id_rs1, id_rs2, id_rd    register fields of the instruction in ID
//   ex_branch_taken          branch/jump resolved taken in EX this cycle
//   stall_pc, stall_ifid     hold PC and IF/ID
//   flush_ifid               invalidate IF/ID
//   ex_*                     EX-stage controls (valid, alu_src, alu_a_sel,
//                            alu_op, branch, jump, illegal)
//   fwd_a, fwd_b             00 regfile, 10 from MEM, 01 from WB
//   mem_*                    MEM-stage controls (valid, mem_read, mem_write)
//   wb_*                     WB-stage controls (valid, reg_write, wb_sel, rd)
//                            wb_sel: 00 ALU, 01 memory, 10 PC+4
// -----------------------------------------------------------------------------
module pipelined_control_unit #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_branch_taken,
    output logic               stall_pc,
    output logic               stall_ifid,
    output logic               flush_ifid,
    output logic               ex_valid,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [1:0]         ex_alu_a_sel,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_illegal,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               mem_valid,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic [1:0]         wb_sel,
    output logic [REG_AW-1:0]  wb_rd
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_BR  = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(2'b11);

    localparam logic [1:0] ASEL_RS1  = 2'b00;
    localparam logic [1:0] ASEL_PC   = 2'b01;
    localparam logic [1:0] ASEL_ZERO = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic               valid;
        logic               alu_src;
        logic [1:0]         alu_a_sel;
        logic [ALUOP_W-1:0] alu_op;
        logic               branch;
        logic               jump;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic [1:0]         wb_sel;
        logic               illegal;
        logic [REG_AW-1:0]  rd;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
    } ex_bundle_t;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [1:0]        wb_sel;
        logic [REG_AW-1:0] rd;
    } mem_bundle_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        wb_sel;
        logic [REG_AW-1:0] rd;
    } wb_bundle_t;

    ex_bundle_t  dec;
    ex_bundle_t  ex_d,  ex_q;
    mem_bundle_t mem_d, mem_q;
    wb_bundle_t  wb_d,  wb_q;

    logic uses_rs1, uses_rs2;
    logic ex_match, mem_match;
    logic load_use, raw_stall, hazard;
    logic flush, stall, bubble;
    logic mem_fwd_ok, wb_fwd_ok;

    // ID decode
    always_comb begin
        dec       = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        dec.valid = 1'b1;
        dec.rd    = id_rd;
        dec.rs1   = id_rs1;
        dec.rs2   = id_rs2;
        case (id_opcode)
            OP_R: begin
                dec.alu_op    = ALU_R;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_IMM: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_I;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_MEM;
                uses_rs1      = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_op    = ALU_BR;
                dec.branch    = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_JAL: begin
                dec.alu_src   = 1'b1;
                dec.alu_a_sel = ASEL_PC;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_PC4;
            end
            OP_JALR: begin
                dec.alu_src   = 1'b1;
                dec.alu_a_sel = ASEL_RS1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_sel    = WB_PC4;
                uses_rs1      = 1'b1;
            end
            OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.alu_a_sel = ASEL_ZERO;
                dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec.alu_src   = 1'b1;
                dec.alu_a_sel = ASEL_PC;
                dec.reg_write = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // x0 is never written, so a rd==0 writer must not look like a producer
        if (id_rd == '0) begin
            dec.reg_write = 1'b0;
        end
    end

    // Hazards, flush and stage-register next state
    always_comb begin
        ex_match  = (ex_q.rd != '0) &&
                    ((uses_rs1 && (ex_q.rd == id_rs1)) || (uses_rs2 && (ex_q.rd == id_rs2)));
        mem_match = (mem_q.rd != '0) &&
                    ((uses_rs1 && (mem_q.rd == id_rs1)) || (uses_rs2 && (mem_q.rd == id_rs2)));
        load_use  = id_valid && ex_q.valid && ex_q.mem_read && ex_match;
        raw_stall = id_valid &&
                    ((ex_q.valid && ex_q.reg_write && ex_match) ||
                     (mem_q.valid && mem_q.reg_write && mem_match));
        hazard    = load_use || (!FWD_EN && raw_stall);
        // The flushed instruction is discarded anyway, so flush wins over stall
        flush     = ex_branch_taken && !reset;
        stall     = hazard && !flush && !reset;
        bubble    = !id_valid || stall || flush;

        ex_d = bubble ? '0 : dec;

        mem_d           = '0;
        mem_d.valid     = ex_q.valid;
        mem_d.mem_read  = ex_q.mem_read;
        mem_d.mem_write = ex_q.mem_write;
        mem_d.reg_write = ex_q.reg_write;
        mem_d.wb_sel    = ex_q.wb_sel;
        mem_d.rd        = ex_q.rd;

        wb_d            = '0;
        wb_d.valid      = mem_q.valid;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.wb_sel     = mem_q.wb_sel;
        wb_d.rd         = mem_q.rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // EX operand forwarding; the younger MEM result takes priority over WB
    always_comb begin
        mem_fwd_ok = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0);
        wb_fwd_ok  = wb_q.valid && wb_q.reg_write && (wb_q.rd != '0);
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        if (FWD_EN) begin
            if (mem_fwd_ok && (mem_q.rd == ex_q.rs1)) begin
                fwd_a = 2'b10;
            end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs1)) begin
                fwd_a = 2'b01;
            end
            if (mem_fwd_ok && (mem_q.rd == ex_q.rs2)) begin
                fwd_b = 2'b10;
            end else if (wb_fwd_ok && (wb_q.rd == ex_q.rs2)) begin
                fwd_b = 2'b01;
            end
        end
    end

    assign stall_pc      = stall;
    assign stall_ifid    = stall;
    assign flush_ifid    = flush;

    assign ex_valid      = ex_q.valid;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_alu_a_sel  = ex_q.alu_a_sel;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_illegal    = ex_q.illegal;

    assign mem_valid     = mem_q.valid;
    assign mem_mem_read  = mem_q.mem_read;
    assign mem_mem_write = mem_q.mem_write;

    assign wb_valid      = wb_q.valid;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_sel        = wb_q.wb_sel;
    assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed testbench for pipelined_control_unit. Each step drives one ID slot,
// checks the combinational stall/flush/forward outputs against hand-derived
// values, and queues the expected EX/MEM/WB bundles for the cycles in which
// they should appear.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken;
    logic       stall_pc, stall_ifid, flush_ifid;
    logic       ex_valid, ex_alu_src, ex_branch, ex_jump, ex_illegal;
    logic [1:0] ex_alu_a_sel, ex_alu_op;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_valid, mem_mem_read, mem_mem_write;
    logic       wb_valid, wb_reg_write;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;

    pipelined_control_unit #(
        .REG_AW (5),
        .ALUOP_W(2),
        .FWD_EN (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .ex_branch_taken(ex_branch_taken),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .flush_ifid     (flush_ifid),
        .ex_valid       (ex_valid),
        .ex_alu_src     (ex_alu_src),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_alu_a_sel   (ex_alu_a_sel),
        .ex_alu_op      (ex_alu_op),
        .ex_illegal     (ex_illegal),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .mem_valid      (mem_valid),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_sel         (wb_sel),
        .wb_rd          (wb_rd)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct {
        int         cyc;
        logic       valid, alu_src, branch, jump, illegal;
        logic       mem_read, mem_write, reg_write;
        logic [1:0] a_sel, alu_op, wb_sel;
        logic [4:0] rd;
    } exp_t;

    exp_t exq[$];
    exp_t memq[$];
    exp_t wbq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic exp_t bubble_exp();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Reference decode table: src / a_sel / aluop / flags
    function automatic exp_t ref_decode(input logic [6:0] op, input logic [4:0] rd);
        exp_t e;
        e = '{default: 0};
        e.valid = 1'b1;
        e.rd    = rd;
        case (op)
            OP_R:      begin e.alu_op = 2'b10; e.reg_write = 1'b1; end
            OP_IMM:    begin e.alu_src = 1'b1; e.alu_op = 2'b11; e.reg_write = 1'b1; end
            OP_LOAD:   begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'b01; end
            OP_STORE:  begin e.alu_src = 1'b1; e.mem_write = 1'b1; end
            OP_BRANCH: begin e.alu_op = 2'b01; e.branch = 1'b1; end
            OP_JAL:    begin e.alu_src = 1'b1; e.a_sel = 2'b01; e.jump = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'b10; end
            OP_JALR:   begin e.alu_src = 1'b1; e.jump = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'b10; end
            OP_LUI:    begin e.alu_src = 1'b1; e.a_sel = 2'b10; e.reg_write = 1'b1; end
            OP_AUIPC:  begin e.alu_src = 1'b1; e.a_sel = 2'b01; e.reg_write = 1'b1; end
            default:   begin e.illegal = 1'b1; end
        endcase
        if (rd == 5'd0) e.reg_write = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_stages();
        exp_t e;
        if (exq.size() > 0 && exq[0].cyc == cyc) begin
            e = exq.pop_front();
            chk("ex_valid",     8'(ex_valid),     8'(e.valid));
            chk("ex_alu_src",   8'(ex_alu_src),   8'(e.alu_src));
            chk("ex_branch",    8'(ex_branch),    8'(e.branch));
            chk("ex_jump",      8'(ex_jump),      8'(e.jump));
            chk("ex_alu_a_sel", 8'(ex_alu_a_sel), 8'(e.a_sel));
            chk("ex_alu_op",    8'(ex_alu_op),    8'(e.alu_op));
            chk("ex_illegal",   8'(ex_illegal),   8'(e.illegal));
        end
        if (memq.size() > 0 && memq[0].cyc == cyc) begin
            e = memq.pop_front();
            chk("mem_valid",     8'(mem_valid),     8'(e.valid));
            chk("mem_mem_read",  8'(mem_mem_read),  8'(e.mem_read));
            chk("mem_mem_write", 8'(mem_mem_write), 8'(e.mem_write));
        end
        if (wbq.size() > 0 && wbq[0].cyc == cyc) begin
            e = wbq.pop_front();
            chk("wb_valid",     8'(wb_valid),     8'(e.valid));
            chk("wb_reg_write", 8'(wb_reg_write), 8'(e.reg_write));
            chk("wb_sel",       8'(wb_sel),       8'(e.wb_sel));
            chk("wb_rd",        8'(wb_rd),        8'(e.rd));
        end
    endtask

    // One ID slot: drive, check comb outputs, queue expectations, clock, check stages
    task automatic step(input int v, input logic [6:0] op, input int r1, input int r2,
                        input int rd, input int tk, input int es, input int ef,
                        input int efa, input int efb);
        exp_t e;
        id_valid        = (v != 0);
        id_opcode       = op;
        id_rs1          = 5'(r1);
        id_rs2          = 5'(r2);
        id_rd           = 5'(rd);
        ex_branch_taken = (tk != 0);
        #1;
        chk("stall_pc",   8'(stall_pc),   8'(es));
        chk("stall_ifid", 8'(stall_ifid), 8'(es));
        chk("flush_ifid", 8'(flush_ifid), 8'(ef));
        chk("fwd_a",      8'(fwd_a),      8'(efa));
        chk("fwd_b",      8'(fwd_b),      8'(efb));
        if (v == 0 || es != 0 || ef != 0) e = bubble_exp();
        else                               e = ref_decode(op, 5'(rd));
        e.cyc = cyc + 1; exq.push_back(e);
        e.cyc = cyc + 2; memq.push_back(e);
        e.cyc = cyc + 3; wbq.push_back(e);
        @(posedge clk);
        cyc++;
        #1;
        check_stages();
    endtask

    task automatic idle();
        step(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset with a load-use-looking instruction in ID; every output must be 0
    task automatic do_reset();
        exp_t e;
        reset           = 1'b1;
        id_valid        = 1'b1;
        id_opcode       = OP_LOAD;
        id_rs1          = 5'd5;
        id_rs2          = 5'd5;
        id_rd           = 5'd5;
        ex_branch_taken = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        chk("rst_stall_pc",     8'(stall_pc),      8'd0);
        chk("rst_stall_ifid",   8'(stall_ifid),    8'd0);
        chk("rst_flush_ifid",   8'(flush_ifid),    8'd0);
        chk("rst_ex_valid",     8'(ex_valid),      8'd0);
        chk("rst_ex_alu_src",   8'(ex_alu_src),    8'd0);
        chk("rst_ex_branch",    8'(ex_branch),     8'd0);
        chk("rst_ex_jump",      8'(ex_jump),       8'd0);
        chk("rst_ex_alu_a_sel", 8'(ex_alu_a_sel),  8'd0);
        chk("rst_ex_alu_op",    8'(ex_alu_op),     8'd0);
        chk("rst_ex_illegal",   8'(ex_illegal),    8'd0);
        chk("rst_fwd_a",        8'(fwd_a),         8'd0);
        chk("rst_fwd_b",        8'(fwd_b),         8'd0);
        chk("rst_mem_valid",    8'(mem_valid),     8'd0);
        chk("rst_mem_mem_read", 8'(mem_mem_read),  8'd0);
        chk("rst_mem_mem_wr",   8'(mem_mem_write), 8'd0);
        chk("rst_wb_valid",     8'(wb_valid),      8'd0);
        chk("rst_wb_reg_write", 8'(wb_reg_write),  8'd0);
        chk("rst_wb_sel",       8'(wb_sel),        8'd0);
        chk("rst_wb_rd",        8'(wb_rd),         8'd0);
        // In-flight work is dropped: later stages must stay empty while refilling
        exq.delete();
        memq.delete();
        wbq.delete();
        e = bubble_exp();
        e.cyc = cyc + 1; memq.push_back(e);
        e.cyc = cyc + 1; wbq.push_back(e);
        e.cyc = cyc + 2; wbq.push_back(e);
        reset    = 1'b0;
        id_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        do_reset();

        // R-type rd=3: +1 alu_op=10 src=0, +3 reg_write, wb_sel=00, rd=3
        step(1, OP_R, 1, 2, 3, 0, 0, 0, 0, 0);
        idle(); idle(); idle();

        // load rd=5 then add rs1=5: one-cycle stall, then WB forward to EX
        step(1, OP_LOAD, 1, 0, 5, 0, 0, 0, 0, 0);
        step(1, OP_R,    5, 2, 6, 0, 1, 0, 0, 0);
        step(1, OP_R,    5, 2, 6, 0, 0, 0, 0, 0);
        step(0, OP_R,    0, 0, 0, 0, 0, 0, 1, 0);
        idle(); idle(); idle();

        // rs2 field of an I-type is not a use; rd=0 load never stalls
        step(1, OP_LOAD, 1, 0, 5, 0, 0, 0, 0, 0);
        step(1, OP_IMM,  1, 5, 7, 0, 0, 0, 0, 0);
        step(1, OP_LOAD, 1, 0, 0, 0, 0, 0, 0, 2);
        step(1, OP_R,    0, 0, 9, 0, 0, 0, 0, 0);
        idle(); idle(); idle();

        // add rd=4, add rd=4, sub rs2=4: MEM beats WB; rd=0 writer never forwards
        step(1, OP_R, 1, 2, 4, 0, 0, 0, 0, 0);
        step(1, OP_R, 1, 2, 4, 0, 0, 0, 0, 0);
        step(1, OP_R, 7, 4, 8, 0, 0, 0, 0, 0);
        step(1, OP_R, 1, 2, 0, 0, 0, 0, 0, 2);
        step(1, OP_R, 0, 0, 9, 0, 0, 0, 0, 0);
        idle();
        idle(); idle(); idle();

        // taken branch with a load-use match in ID: flush wins, no stall
        step(1, OP_LOAD, 1, 0, 5, 0, 0, 0, 0, 0);
        step(1, OP_R,    5, 2, 6, 1, 0, 1, 0, 0);
        idle(); idle(); idle();

        // undecodable opcode
        step(1, OP_BAD, 3, 4, 6, 0, 0, 0, 0, 0);
        idle(); idle(); idle();

        // decode sweep over the remaining opcode classes
        step(1, OP_JAL,    0,  0,  1, 0, 0, 0, 0, 0);
        step(1, OP_JALR,   20, 0,  11, 0, 0, 0, 0, 0);
        step(1, OP_LUI,    0,  0,  12, 0, 0, 0, 0, 0);
        step(1, OP_AUIPC,  0,  0,  13, 0, 0, 0, 0, 0);
        step(1, OP_STORE,  21, 22, 0, 0, 0, 0, 0, 0);
        step(1, OP_BRANCH, 23, 24, 0, 0, 0, 0, 0, 0);
        step(1, OP_IMM,    25, 0,  14, 0, 0, 0, 0, 0);
        idle(); idle(); idle();

        // reset mid-stream drops in-flight instructions
        step(1, OP_R,    1, 2, 15, 0, 0, 0, 0, 0);
        step(1, OP_LOAD, 1, 2, 16, 0, 0, 0, 0, 0);
        do_reset();
        idle(); idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
